// File: rtl/sensor_pkg.sv
// Shared types and constants for the pad sensor conditioning path.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        REARM = 2'd2
    } pad_state_t;

    localparam int PAD_W = 5;
    localparam logic [31:0] SENSOR_IDLE = 32'hFFFF_FFFF;

    function automatic int pad_lsb(input int p);
        return PAD_W * p;
    endfunction

endpackage

// File: rtl/bit_debouncer.sv
// Two-flop synchronizer followed by a stable-level debouncer for one active-low sensor line.
module bit_debouncer #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    input  logic raw,
    output logic stable
);

    logic        sync_a;
    logic        sync_b;
    logic [15:0] cnt;

    // The counter only runs while the synchronized sample disagrees with the
    // accepted level; any agreement restarts the qualification window.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == 16'(DEBOUNCE_CYC - 1)) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the raw pad sensors and stretches each pad hit into a held,
// accumulated active-low pattern for the VGA game stage.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int N_PADS       = 3,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int HOLD_CYC     = 2500000
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic [N_PADS*PAD_W-1:0]   sensor_raw,
    input  logic [N_PADS-1:0]         hit_ack,
    output logic [31:0]               sensor_out,
    output logic [N_PADS-1:0]         pad_hit,
    output logic [N_PADS-1:0]         pad_busy
);

    localparam int BITS = N_PADS * PAD_W;

    logic [BITS-1:0] deb;
    logic [BITS-1:0] latch_flat;

    for (genvar b = 0; b < BITS; b++) begin : g_bit
        bit_debouncer #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .iVGA_CLK(iVGA_CLK),
            .iRST_n  (iRST_n),
            .raw     (sensor_raw[b]),
            .stable  (deb[b])
        );
    end

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        pad_state_t       state;
        logic [PAD_W-1:0] latch;
        logic [PAD_W-1:0] dp;
        logic [23:0]      hold_cnt;
        logic             hit_r;

        assign dp = deb[pad_lsb(p) +: PAD_W];

        // Exiting HOLD releases the pattern on the same edge, so the pattern
        // is visible for exactly HOLD_CYC cycles or until one cycle after ack.
        always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
            if (!iRST_n) begin
                state    <= IDLE;
                latch    <= '1;
                hold_cnt <= '0;
                hit_r    <= 1'b0;
            end else begin
                hit_r <= 1'b0;
                case (state)
                    IDLE: begin
                        if (dp != '1) begin
                            latch    <= dp;
                            hit_r    <= 1'b1;
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == 24'(HOLD_CYC - 1) || hit_ack[p]) begin
                            latch <= '1;
                            state <= REARM;
                        end else begin
                            latch    <= latch & dp;
                            hold_cnt <= hold_cnt + 24'd1;
                        end
                    end
                    REARM: begin
                        latch <= '1;
                        if (dp == '1) state <= IDLE;
                    end
                    default: begin
                        latch <= '1;
                        state <= IDLE;
                    end
                endcase
            end
        end

        assign latch_flat[pad_lsb(p) +: PAD_W] = latch;
        assign pad_hit[p]  = hit_r;
        assign pad_busy[p] = (state != IDLE);
    end

    assign sensor_out = {SENSOR_IDLE[31:BITS], latch_flat};

endmodule
